hilo_muldiv_ctrl: RTL

//  Sequences the HI/LO multiply/divide resource for the EX stage. Consumes the decoded MULT/DIV/MFHL/MTHL
//  one-hot pairs and the rs/rt operand values. Runs a pipelined multiplier (MUL_LAT cycles) or an

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 52 +++++
 rtl/hilo_muldiv_ctrl_if.sv | 27 ++
 rtl/div_iter_radix2.sv | 76 +++++++
 rtl/hilo_muldiv_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: FSM encodings,
// decoder bit positions of the one-hot instruction pairs, and the priority decode.
package hilo_muldiv_ctrl_pkg;

    localparam int HILO_DATA_W = 32;

    localparam int MULT_S_BIT = 0;
    localparam int MULT_U_BIT = 1;
    localparam int DIV_S_BIT  = 0;
    localparam int DIV_U_BIT  = 1;
    localparam int MFLO_BIT   = 0;
    localparam int MFHI_BIT   = 1;
    localparam int MTLO_BIT   = 0;
    localparam int MTHI_BIT   = 1;

    typedef enum logic [1:0] {
        HILO_IDLE = 2'd0,
        HILO_MUL  = 2'd1,
        HILO_DIV  = 2'd2
    } hilo_state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } hilo_op_e;

    // A multi-hot input from a faulty decode resolves to exactly one operation.
    function automatic hilo_op_e decode_op(input logic [1:0] mult,
                                           input logic [1:0] div,
                                           input logic [1:0] mfhl,
                                           input logic [1:0] mthl);
        hilo_op_e op;
        if (mult[MULT_S_BIT])      op = OP_MULT;
        else if (mult[MULT_U_BIT]) op = OP_MULTU;
        else if (div[DIV_S_BIT])   op = OP_DIV;
        else if (div[DIV_U_BIT])   op = OP_DIVU;
        else if (mthl[MTHI_BIT])   op = OP_MTHI;
        else if (mthl[MTLO_BIT])   op = OP_MTLO;
        else if (mfhl[MFHI_BIT])   op = OP_MFHI;
        else if (mfhl[MFLO_BIT])   op = OP_MFLO;
        else                       op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage side of the HI/LO resource: decoded instruction, operands, and results.
interface hilo_muldiv_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              op_valid;
    logic [1:0]        mult;
    logic [1:0]        div;
    logic [1:0]        mfhl;
    logic [1:0]        mthl;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              stall;
    logic              busy;
    logic [DATA_W-1:0] hilo_rdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output op_valid, mult, div, mfhl, mthl, src_a, src_b,
        input  stall, busy, hilo_rdata, hi, lo
    );

    modport slave (
        input  op_valid, mult, div, mfhl, mthl, src_a, src_b,
        output stall, busy, hilo_rdata, hi, lo
    );
endinterface

// File: rtl/div_iter_radix2.sv
// Iterative restoring divider: magnitudes loaded on start, DATA_W shift-subtract
// steps, then sign-corrected quotient/remainder held while done is high.
module div_iter_radix2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem
);
    localparam int STEP_W = $clog2(DATA_W + 1);

    logic              a_neg_s, b_neg_s;
    logic [DATA_W-1:0] a_mag_s, b_mag_s;
    logic [DATA_W:0]   r_shift_s;
    logic              sub_ok_s;
    logic [DATA_W-1:0] r_step_s, q_step_s;

    logic              run_q;
    logic [STEP_W-1:0] step_q;
    logic [DATA_W-1:0] q_q, r_q, d_q;
    logic              q_neg_q, r_neg_q, dz_q;

    assign a_neg_s = signed_op & a[DATA_W-1];
    assign b_neg_s = signed_op & b[DATA_W-1];
    assign a_mag_s = a_neg_s ? ({DATA_W{1'b0}} - a) : a;
    assign b_mag_s = b_neg_s ? ({DATA_W{1'b0}} - b) : b;

    // Remainder stays below the divisor, so the trial difference always fits DATA_W bits.
    assign r_shift_s = {r_q, q_q[DATA_W-1]};
    assign sub_ok_s  = (r_shift_s >= {1'b0, d_q});
    assign r_step_s  = sub_ok_s ? (r_shift_s[DATA_W-1:0] - d_q) : r_shift_s[DATA_W-1:0];
    assign q_step_s  = {q_q[DATA_W-2:0], sub_ok_s};

    assign done = run_q & (step_q == {STEP_W{1'b0}});
    // Divide-by-zero keeps the raw all-ones quotient; the remainder fix restores src_a.
    assign quot = dz_q ? {DATA_W{1'b1}} : (q_neg_q ? ({DATA_W{1'b0}} - q_q) : q_q);
    assign rem  = r_neg_q ? ({DATA_W{1'b0}} - r_q) : r_q;

    // Load on start, then one restoring step per cycle until the step count runs out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q   <= 1'b0;
            step_q  <= {STEP_W{1'b0}};
            q_q     <= {DATA_W{1'b0}};
            r_q     <= {DATA_W{1'b0}};
            d_q     <= {DATA_W{1'b0}};
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (start) begin
            run_q   <= 1'b1;
            step_q  <= STEP_W'(DATA_W);
            q_q     <= a_mag_s;
            r_q     <= {DATA_W{1'b0}};
            d_q     <= b_mag_s;
            q_neg_q <= a_neg_s ^ b_neg_s;
            r_neg_q <= a_neg_s;
            dz_q    <= (b == {DATA_W{1'b0}});
        end else if (run_q) begin
            if (step_q != {STEP_W{1'b0}}) begin
                q_q    <= q_step_s;
                r_q    <= r_step_s;
                step_q <= step_q - {{(STEP_W-1){1'b0}}, 1'b1};
            end else begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: issues multiplies and divides, commits results
// to HI/LO, services mthi/mtlo/mfhi/mflo, and stalls HI/LO users while busy.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W  = HILO_DATA_W,
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                resetn,
    hilo_muldiv_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    hilo_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   mul_a_q, mul_b_q;
    logic                mul_signed_q;

    hilo_op_e            op_s;
    logic                hilo_op_s, accept_s;
    logic                mul_start_s, div_start_s;
    logic [DATA_W-1:0]   rdata_s;
    logic signed [DATA_W:0]     mul_a_ext_s, mul_b_ext_s;
    logic signed [2*DATA_W-1:0] mul_prod_s;
    logic [2*DATA_W-1:0] mul_res_s;
    logic                div_done_s;
    logic [DATA_W-1:0]   div_quot_s, div_rem_s;

    assign op_s        = decode_op(bus.mult, bus.div, bus.mfhl, bus.mthl);
    assign hilo_op_s   = |{bus.mult, bus.div, bus.mfhl, bus.mthl};
    assign accept_s    = bus.op_valid & hilo_op_s & ~busy_q;
    assign mul_start_s = accept_s & ((op_s == OP_MULT) | (op_s == OP_MULTU));
    assign div_start_s = accept_s & ((op_s == OP_DIV) | (op_s == OP_DIVU));

    assign bus.stall      = bus.op_valid & hilo_op_s & busy_q;
    assign bus.busy       = busy_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.hilo_rdata = rdata_s;

    // Read port is live only for an accepted mfhi/mflo; stalled reads return zero.
    always_comb begin
        rdata_s = {DATA_W{1'b0}};
        if (accept_s) begin
            case (op_s)
                OP_MFHI: rdata_s = hi_q;
                OP_MFLO: rdata_s = lo_q;
                default: rdata_s = {DATA_W{1'b0}};
            endcase
        end else begin
            rdata_s = {DATA_W{1'b0}};
        end
    end

    // Multiplier operands are captured once at issue so EX can move on.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mul_a_q      <= {DATA_W{1'b0}};
            mul_b_q      <= {DATA_W{1'b0}};
            mul_signed_q <= 1'b0;
        end else if (mul_start_s) begin
            mul_a_q      <= bus.src_a;
            mul_b_q      <= bus.src_b;
            mul_signed_q <= (op_s == OP_MULT);
        end
    end

    // One signed multiply covers both flavours: unsigned operands get a zero extension bit.
    assign mul_a_ext_s = $signed({mul_signed_q & mul_a_q[DATA_W-1], mul_a_q});
    assign mul_b_ext_s = $signed({mul_signed_q & mul_b_q[DATA_W-1], mul_b_q});
    assign mul_prod_s  = mul_a_ext_s * mul_b_ext_s;

    if (MUL_LAT == 1) begin : g_mul_comb
        assign mul_res_s = mul_prod_s;
    end else begin : g_mul_pipe
        logic [2*DATA_W-1:0] pipe_q [MUL_LAT-1];

        // Plain delay stages behind the multiplier, left for synthesis to retime.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int i = 0; i < MUL_LAT - 1; i++) begin
                    pipe_q[i] <= {(2*DATA_W){1'b0}};
                end
            end else begin
                pipe_q[0] <= mul_prod_s;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign mul_res_s = pipe_q[MUL_LAT-2];
    end

    div_iter_radix2 #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start_s),
        .signed_op (op_s == OP_DIV),
        .a         (bus.src_a),
        .b         (bus.src_b),
        .done      (div_done_s),
        .quot      (div_quot_s),
        .rem       (div_rem_s)
    );

    // Next-state logic: issue from IDLE, count down, commit to HI/LO at cnt == 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            HILO_IDLE: begin
                if (accept_s) begin
                    case (op_s)
                        OP_MULT, OP_MULTU: begin
                            state_d = HILO_MUL;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = HILO_DIV;
                            cnt_d   = CNT_W'(DATA_W);
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: state_d = HILO_IDLE;
                    endcase
                end else begin
                    state_d = HILO_IDLE;
                end
            end
            HILO_MUL: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    {hi_d, lo_d} = mul_res_s;
                    state_d      = HILO_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            HILO_DIV: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    if (div_done_s) begin
                        lo_d    = div_quot_s;
                        hi_d    = div_rem_s;
                        state_d = HILO_IDLE;
                    end else begin
                        state_d = HILO_DIV;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = HILO_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign busy_d = (state_d != HILO_IDLE);

    // Architectural state register; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= HILO_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            hi_q    <= {DATA_W{1'b0}};
            lo_q    <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
